turret_servo_ctrl: RTL and testbench
====================================

TURRET_SERVO_CTRL -- requirements
Module: turret_servo_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- PERIOD_CYC, 500000: servo PWM frame length in clocks (20 ms at 25 MHz).
- MIN_CYC, 25000: pulse width at position 0.
- STEP_CYC, 98: added pulse width per position step.
- FIRE_CYC, 2500000: fire pulse length.
- COOL_CYC, 12500000: lockout after a fire pulse.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1: the single clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_right / i_left, in, 1: level commands from the UART command decoder; move pan +1 / -1.
- i_up / i_down, in, 1: level commands; move tilt +1 / -1.
- i_trigger, in, 1: level fire request.
- o_pwm_pan / o_pwm_tilt, out, 1: servo PWM outputs.
- o_fire, out, 1: fire actuator drive.
- o_busy, out, 1: fire FSM not IDLE.
- o_pan_pos / o_tilt_pos, out, 8: current positions.
REQ-003 SHALL give all inputs as synchronous to i_clk; the block performs no synchronisation.
REQ-004 SHALL require MIN_CYC + 255*STEP_CYC < PERIOD_CYC; the behaviour outside this constraint is undefined.

Function
REQ-005 SHALL run a frame counter from 0 to PERIOD_CYC-1 and wrap to 0.
REQ-006 SHALL update positions only on the cycle where frame counter == PERIOD_CYC-1, i.e. one step per frame while a command is held.
REQ-007 SHALL increment pan when i_right=1 and i_left=0, decrement it when i_left=1 and i_right=0, and hold it when both or neither are set.
REQ-008 SHALL apply the REQ-007 rule to tilt, with i_up as increment and i_down as decrement.
REQ-009 SHALL saturate positions: 255 +1 stays 255 and 0 -1 stays 0, with no wrap-around.
REQ-010 SHALL latch the pulse width MIN_CYC + pos*STEP_CYC into a per-axis register at frame counter == 0, so width never changes mid-frame.
REQ-011 SHALL register PWM outputs: o_pwm is 1 on the cycle after any cycle where frame counter < latched width, otherwise 0 (one-cycle latency).
REQ-012 SHALL make the positions updated at the end of frame N affect pulse width from frame N+1 onward.
REQ-013 SHALL run the fire FSM through three states:
- IDLE goes to FIRE on a rising edge of i_trigger, meaning the registered previous value was 0 and the current value is 1.
- FIRE holds o_fire=1 for exactly FIRE_CYC cycles, then goes to COOL.
- COOL holds o_fire=0 for exactly COOL_CYC cycles, then goes to IDLE.
REQ-014 SHALL ignore trigger edges during FIRE and COOL; a trigger held high through the return to IDLE does not refire until it goes low and then high again.
REQ-015 SHALL make o_fire high on the cycle after the rising-edge cycle.
REQ-016 SHALL drive o_busy=1 in FIRE and COOL and 0 in IDLE.
REQ-017 SHALL keep fire handling and movement independent; simultaneous trigger and direction commands are both acted on.

Reset
REQ-018 SHALL, while i_rst=1 at a clock edge, set the following on that edge:
- frame counter 0.
- pan and tilt positions 128.
- latched widths MIN_CYC + 128*STEP_CYC.
- o_pwm_pan, o_pwm_tilt and o_fire all 0.
- fire FSM IDLE.
- trigger history 0.
REQ-019 SHALL abort a reset asserted mid-fire or mid-frame immediately (o_fire=0 the next cycle), without completing the current pulse.
REQ-020 SHALL raise o_pwm on the second cycle after reset deasserts, at the centred width.
REQ-021 SHALL treat a trigger held high during reset release as a rising edge, because the trigger history is 0.

Configuration
REQ-022 SHALL support macro TURRET_CENTER_EN:
- Defined: adds input i_center (1 bit); i_center=1 at the frame-end update forces both positions to 128, overriding direction commands.
- Undefined: port absent; behaviour as REQ-006..009 only.

Verification
Bench parameters: PERIOD_CYC=1000, MIN_CYC=100, STEP_CYC=2, FIRE_CYC=20, COOL_CYC=50.
REQ-023 SHALL cover reset then idle: pan/tilt=128, and o_pwm high for 356 cycles per 1000-cycle frame.
REQ-024 SHALL cover saturation: i_right held for 130 frames -> pan counts up to 255 and stays there, pulse width 610; then i_left held for 260 frames -> pan=0, width 100.
REQ-025 SHALL cover conflicting commands: i_up=i_down=1 for 5 frames -> tilt stays 128; i_right asserted mid-frame -> pan changes only at counter 999, and the width changes in the following frame.
REQ-026 SHALL cover fire with lockout:
- trigger pulsed at cycle T -> o_fire high from T+1 to T+20, o_busy high from T+1 to T+70.
- a second pulse at T+30 is ignored.
- trigger held high to T+100 -> no refire.
REQ-027 SHALL cover reset mid-fire: i_rst at T+10 -> o_fire=0, o_busy=0 and positions 128 on the next cycle.
REQ-028 SHALL cover the macro: with TURRET_CENTER_EN defined, pan=200, then i_center=1 together with i_right -> pan=128 after the frame end.

Source files
------------

// File: rtl/turret_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turret_servo_ctrl
// Description : Pan/tilt servo PWM positioner with a fire pulse and cooldown
//               sequencer. Define TURRET_CENTER_EN to add i_center, which
//               recentres both axes at the frame-end update.
// Revision    : 1.0 - initial release
// ============================================================================
module turret_servo_ctrl #(
    parameter int unsigned PERIOD_CYC = 500000,
    parameter int unsigned MIN_CYC    = 25000,
    parameter int unsigned STEP_CYC   = 98,
    parameter int unsigned FIRE_CYC   = 2500000,
    parameter int unsigned COOL_CYC   = 12500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_right,
    input  logic       i_left,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_trigger,
`ifdef TURRET_CENTER_EN
    input  logic       i_center,
`endif
    output logic       o_pwm_pan,
    output logic       o_pwm_tilt,
    output logic       o_fire,
    output logic       o_busy,
    output logic [7:0] o_pan_pos,
    output logic [7:0] o_tilt_pos
);

    localparam int unsigned     C_CW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [C_CW-1:0] C_FRAME_LAST = C_CW'(PERIOD_CYC - 1);
    localparam logic [7:0]      C_POS_CENTER = 8'd128;
    localparam int unsigned     C_TMAX       = (FIRE_CYC > COOL_CYC) ? FIRE_CYC : COOL_CYC;
    localparam int unsigned     C_TW         = $clog2(C_TMAX + 1);
    localparam logic [C_TW-1:0] C_FIRE_LAST  = C_TW'(FIRE_CYC - 1);
    localparam logic [C_TW-1:0] C_COOL_LAST  = C_TW'(COOL_CYC - 1);

    function automatic logic [C_CW-1:0] pulse_width(input logic [7:0] pos);
        return C_CW'(MIN_CYC + {24'd0, pos} * STEP_CYC);
    endfunction

    // Saturating one-step move; opposing or absent commands hold position.
    function automatic logic [7:0] step_pos(input logic [7:0] pos,
                                            input logic       inc,
                                            input logic       dec);
        logic [7:0] res;
        res = pos;
        if (inc && !dec && (pos != 8'd255)) begin
            res = pos + 8'd1;
        end else if (dec && !inc && (pos != 8'd0)) begin
            res = pos - 8'd1;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Frame timing, positions and PWM generation
    // ------------------------------------------------------------------
    logic [C_CW-1:0] r_frame_cnt;
    logic [7:0]      r_pan_pos;
    logic [7:0]      r_tilt_pos;
    logic [C_CW-1:0] r_pan_width;
    logic [C_CW-1:0] r_tilt_width;
    logic            r_pwm_pan;
    logic            r_pwm_tilt;
    logic            w_frame_end;
    logic            w_center;

    assign w_frame_end = (r_frame_cnt == C_FRAME_LAST);

`ifdef TURRET_CENTER_EN
    assign w_center = i_center;
`else
    assign w_center = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt  <= '0;
            r_pan_pos    <= C_POS_CENTER;
            r_tilt_pos   <= C_POS_CENTER;
            r_pan_width  <= pulse_width(C_POS_CENTER);
            r_tilt_width <= pulse_width(C_POS_CENTER);
            r_pwm_pan    <= 1'b0;
            r_pwm_tilt   <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + 1'b1;

            // Width is captured once per frame so a pulse never changes mid-frame.
            if (r_frame_cnt == '0) begin
                r_pan_width  <= pulse_width(r_pan_pos);
                r_tilt_width <= pulse_width(r_tilt_pos);
            end

            if (w_frame_end) begin
                if (w_center) begin
                    r_pan_pos  <= C_POS_CENTER;
                    r_tilt_pos <= C_POS_CENTER;
                end else begin
                    r_pan_pos  <= step_pos(r_pan_pos, i_right, i_left);
                    r_tilt_pos <= step_pos(r_tilt_pos, i_up, i_down);
                end
            end

            r_pwm_pan  <= (r_frame_cnt < r_pan_width);
            r_pwm_tilt <= (r_frame_cnt < r_tilt_width);
        end
    end

    assign o_pwm_pan  = r_pwm_pan;
    assign o_pwm_tilt = r_pwm_tilt;
    assign o_pan_pos  = r_pan_pos;
    assign o_tilt_pos = r_tilt_pos;

    // ------------------------------------------------------------------
    // Fire sequencer: IDLE -> FIRE (FIRE_CYC) -> COOL (COOL_CYC) -> IDLE
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_COOL = 2'd2
    } fire_state_t;

    fire_state_t     r_state;
    fire_state_t     w_state_nxt;
    logic [C_TW-1:0] r_tmr;
    logic [C_TW-1:0] w_tmr_nxt;
    logic            r_trig_prev;
    logic            w_trig_rise;

    // History tracks the trigger in every state, so a level held through
    // the lockout produces no edge when IDLE is reached.
    assign w_trig_rise = i_trigger & ~r_trig_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_trig_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_trig_prev <= i_trigger;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (w_trig_rise) begin
                    w_state_nxt = S_FIRE;
                    w_tmr_nxt   = '0;
                end
            end
            S_FIRE: begin
                if (r_tmr == C_FIRE_LAST) begin
                    w_state_nxt = S_COOL;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_COOL: begin
                if (r_tmr == C_COOL_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    assign o_fire = (r_state == S_FIRE);
    assign o_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_turret_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_turret_servo_ctrl
// Description : Scoreboard bench driving two turret_servo_ctrl instances
//               (nominal and short-frame) from one randomized input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turret_servo_ctrl;

    localparam int M_PERIOD = 1000;
    localparam int M_MIN    = 100;
    localparam int M_STEP   = 2;
    localparam int M_FIRE   = 20;
    localparam int M_COOL   = 50;
    localparam int S_PERIOD = 260;
    localparam int S_MIN    = 1;
    localparam int S_STEP   = 1;
    localparam int S_FIRE   = 5;
    localparam int S_COOL   = 7;

    typedef struct packed {
        logic [7:0] pan;
        logic [7:0] tilt;
        logic       pwm_p;
        logic       pwm_t;
        logic       fire;
        logic       busy;
    } obs_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic right   = 1'b0;
    logic left    = 1'b0;
    logic up      = 1'b0;
    logic down    = 1'b0;
    logic trigger = 1'b0;
`ifdef TURRET_CENTER_EN
    logic center  = 1'b0;
`endif

    logic       d_pwm_pan  [2];
    logic       d_pwm_tilt [2];
    logic       d_fire     [2];
    logic       d_busy     [2];
    logic [7:0] d_pan_pos  [2];
    logic [7:0] d_tilt_pos [2];

    int n_tests = 0;
    int n_fail  = 0;

    int prm_period [2] = '{M_PERIOD, S_PERIOD};
    int prm_min    [2] = '{M_MIN, S_MIN};
    int prm_step   [2] = '{M_STEP, S_STEP};
    int prm_fire   [2] = '{M_FIRE, S_FIRE};
    int prm_cool   [2] = '{M_COOL, S_COOL};

    // Reference model: position within frame, axis positions, the width in
    // force for the current frame, and cycles elapsed since the fire started.
    int   t       [2];
    int   pan     [2];
    int   tilt    [2];
    int   fw_pan  [2];
    int   fw_tilt [2];
    int   since   [2];
    logic trig_prev = 1'b0;
    obs_t q0[$];
    obs_t q1[$];

    always #5 clk = ~clk;

    turret_servo_ctrl #(
        .PERIOD_CYC(M_PERIOD), .MIN_CYC(M_MIN), .STEP_CYC(M_STEP),
        .FIRE_CYC(M_FIRE), .COOL_CYC(M_COOL)
    ) u_dut_main (
        .i_clk(clk), .i_rst(rst),
        .i_right(right), .i_left(left), .i_up(up), .i_down(down),
        .i_trigger(trigger),
`ifdef TURRET_CENTER_EN
        .i_center(center),
`endif
        .o_pwm_pan(d_pwm_pan[0]), .o_pwm_tilt(d_pwm_tilt[0]),
        .o_fire(d_fire[0]), .o_busy(d_busy[0]),
        .o_pan_pos(d_pan_pos[0]), .o_tilt_pos(d_tilt_pos[0])
    );

    turret_servo_ctrl #(
        .PERIOD_CYC(S_PERIOD), .MIN_CYC(S_MIN), .STEP_CYC(S_STEP),
        .FIRE_CYC(S_FIRE), .COOL_CYC(S_COOL)
    ) u_dut_short (
        .i_clk(clk), .i_rst(rst),
        .i_right(right), .i_left(left), .i_up(up), .i_down(down),
        .i_trigger(trigger),
`ifdef TURRET_CENTER_EN
        .i_center(center),
`endif
        .o_pwm_pan(d_pwm_pan[1]), .o_pwm_tilt(d_pwm_tilt[1]),
        .o_fire(d_fire[1]), .o_busy(d_busy[1]),
        .o_pan_pos(d_pan_pos[1]), .o_tilt_pos(d_tilt_pos[1])
    );

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : ((v < 0) ? 0 : v);
    endfunction

    function automatic int dir(input logic inc, input logic dec);
        return (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
    endfunction

    // Predict the outputs following the next rising edge from current inputs.
    task automatic model_edge();
        obs_t e;
        logic ctr;
        ctr = 1'b0;
`ifdef TURRET_CENTER_EN
        ctr = center;
`endif
        for (int i = 0; i < 2; i++) begin
            e = '0;
            if (rst) begin
                t[i]     = 0;
                pan[i]   = 128;
                tilt[i]  = 128;
                since[i] = -1;
            end else begin
                if (t[i] == 0) begin
                    fw_pan[i]  = prm_min[i] + pan[i] * prm_step[i];
                    fw_tilt[i] = prm_min[i] + tilt[i] * prm_step[i];
                end
                e.pwm_p = (t[i] < fw_pan[i]);
                e.pwm_t = (t[i] < fw_tilt[i]);
                if (t[i] == prm_period[i] - 1) begin
                    t[i] = 0;
                    if (ctr) begin
                        pan[i]  = 128;
                        tilt[i] = 128;
                    end else begin
                        pan[i]  = sat8(pan[i] + dir(right, left));
                        tilt[i] = sat8(tilt[i] + dir(up, down));
                    end
                end else begin
                    t[i]++;
                end
                if (since[i] < 0) begin
                    if (trigger && !trig_prev) since[i] = 0;
                end else begin
                    since[i]++;
                    if (since[i] == prm_fire[i] + prm_cool[i]) since[i] = -1;
                end
            end
            e.pan  = 8'(pan[i]);
            e.tilt = 8'(tilt[i]);
            e.fire = (since[i] >= 0) && (since[i] < prm_fire[i]);
            e.busy = (since[i] >= 0);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        trig_prev = rst ? 1'b0 : trigger;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare(input int i, input obs_t e);
        obs_t a;
        a.pan   = d_pan_pos[i];
        a.tilt  = d_tilt_pos[i];
        a.pwm_p = d_pwm_pan[i];
        a.pwm_t = d_pwm_tilt[i];
        a.fire  = d_fire[i];
        a.busy  = d_busy[i];
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL obs dut%0d @%0t: got pan=%0d tilt=%0d pwm=%b%b fire=%b busy=%b, expected pan=%0d tilt=%0d pwm=%b%b fire=%b busy=%b",
                     i, $time, a.pan, a.tilt, a.pwm_p, a.pwm_t, a.fire, a.busy,
                     e.pan, e.tilt, e.pwm_p, e.pwm_t, e.fire, e.busy);
        end
    endtask

    // Monitor: every cycle the DUTs present a new observation.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, e);
            end
        end
    end

    initial begin
        int hi_p;
        int hi_t;
        int tilt_before;
        @(negedge clk);

        // Reset, then two idle frames on the nominal instance.
        rst = 1'b1;
        cyc(3);
        rst  = 1'b0;
        hi_p = 0;
        hi_t = 0;
        for (int k = 0; k < 2 * M_PERIOD; k++) begin
            model_edge();
            @(negedge clk);
            if (d_pwm_pan[0] === 1'b1)  hi_p++;
            if (d_pwm_tilt[0] === 1'b1) hi_t++;
        end
        check("idle_duty_pan", hi_p, 712);
        check("idle_duty_tilt", hi_t, 712);
        check("idle_pan_pos", int'(d_pan_pos[0]), 128);

        // Saturation: pan driven up, tilt driven down, 130 short frames.
        right = 1'b1;
        down  = 1'b1;
        cyc(129 * S_PERIOD);
        hi_p = 0;
        hi_t = 0;
        for (int k = 0; k < S_PERIOD; k++) begin
            model_edge();
            @(negedge clk);
            if (d_pwm_pan[1] === 1'b1)  hi_p++;
            if (d_pwm_tilt[1] === 1'b1) hi_t++;
        end
        check("sat_width_hi", hi_p, 256);
        check("sat_width_lo", hi_t, 1);
        check("sat_pan_255", int'(d_pan_pos[1]), 255);
        check("sat_tilt_0", int'(d_tilt_pos[1]), 0);
        right = 1'b0;
        down  = 1'b0;

        // Conflicting commands hold both axes.
        tilt_before = tilt[0];
        up    = 1'b1;
        down  = 1'b1;
        right = 1'b1;
        left  = 1'b1;
        cyc(5 * M_PERIOD);
        check("conflict_tilt", int'(d_tilt_pos[0]), tilt_before);
        up    = 1'b0;
        down  = 1'b0;
        right = 1'b0;
        left  = 1'b0;

        // Randomized commands and trigger activity.
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 299) == 0) right = ~right;
            if ($urandom_range(0, 299) == 0) left  = ~left;
            if ($urandom_range(0, 399) == 0) up    = ~up;
            if ($urandom_range(0, 399) == 0) down  = ~down;
            if ($urandom_range(0, 39) == 0)  trigger = ~trigger;
`ifdef TURRET_CENTER_EN
            center = ($urandom_range(0, 499) == 0);
`endif
            model_edge();
            @(negedge clk);
        end
        right   = 1'b0;
        left    = 1'b0;
        up      = 1'b0;
        down    = 1'b0;
        trigger = 1'b0;
`ifdef TURRET_CENTER_EN
        center  = 1'b0;
`endif
        cyc(200);

        // Fire with lockout: pulse at T, second pulse at T+30, held T+60..T+100.
        trigger = 1'b1;
        cyc(1);
        check("fire_start", int'(d_fire[0]), 1);
        trigger = 1'b0;
        cyc(29);
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
        cyc(29);
        trigger = 1'b1;
        cyc(41);
        trigger = 1'b0;
        cyc(200);
        check("fire_idle_after", int'(d_busy[0]), 0);

        // Reset mid-fire.
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
        cyc(9);
        rst = 1'b1;
        cyc(1);
        check("rst_fire", int'(d_fire[0]), 0);
        check("rst_busy", int'(d_busy[0]), 0);
        check("rst_pan", int'(d_pan_pos[0]), 128);
        rst = 1'b0;
        cyc(100);

        // Trigger held high across reset release counts as an edge.
        rst     = 1'b1;
        trigger = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("trig_rst_release", int'(d_fire[0]), 1);
        cyc(10);
        trigger = 1'b0;
        cyc(200);

`ifdef TURRET_CENTER_EN
        // Drive short-instance pan to 200, then recentre while still moving right.
        rst = 1'b1;
        cyc(1);
        rst   = 1'b0;
        right = 1'b1;
        cyc(72 * S_PERIOD);
        check("center_pre", int'(d_pan_pos[1]), 200);
        center = 1'b1;
        cyc(S_PERIOD);
        check("center_post", int'(d_pan_pos[1]), 128);
        center = 1'b0;
        right  = 1'b0;
        cyc(100);
`endif

        cyc(5);
        check("queue_drain", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
